// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one simple dual-port RAM (write port A, read port B)
// between NREQ requesters. Independent round-robin arbitration for writes and
// reads, same-cycle read-after-write hazard masking, and one-hot read response
// one cycle after the read grant.
module ram_port_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 10,
  parameter int DW   = 16
) (
  input  logic              clka,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              ena,
  output logic              enb,
  output logic              wea,
  output logic [AW-1:0]     addra,
  output logic [AW-1:0]     addrb,
  output logic [DW-1:0]     dia,
  input  logic [DW-1:0]     dob
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [NREQ-1:0] r_rsp_valid;

  logic [NREQ-1:0] w_wr_cand;
  logic [NREQ-1:0] w_rd_cand;
  logic [NREQ-1:0] w_hazard;
  logic            w_wr_found;
  logic            w_rd_found;
  logic [PW-1:0]   w_wr_idx;
  logic [PW-1:0]   w_rd_idx;
  logic [AW-1:0]   w_wr_addr;
  logic [DW-1:0]   w_wr_data;
  logic [AW-1:0]   w_rd_addr;
  logic            w_wr_gnt;
  logic            w_rd_gnt;

  // First candidate at or after ptr, wrapping past NREQ-1; returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] cand,
                                          input logic [PW-1:0]   ptr);
    logic          found;
    logic [PW-1:0] sel;
    int            idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && cand[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
    return {found, sel};
  endfunction

  assign {w_wr_found, w_wr_idx} = rr_pick(w_wr_cand, r_wr_ptr);
  assign w_wr_addr = req_addr[w_wr_idx*AW +: AW];
  assign w_wr_data = req_wdata[w_wr_idx*DW +: DW];

  // A reader targeting the address being written this cycle waits a cycle so
  // it observes the completed write instead of the stale word.
  assign {w_rd_found, w_rd_idx} = rr_pick(w_rd_cand, r_rd_ptr);
  assign w_rd_addr = req_addr[w_rd_idx*AW +: AW];

  // Reset overrides every grant combinationally.
  assign w_wr_gnt = w_wr_found & ~rst;
  assign w_rd_gnt = w_rd_found & ~rst;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_wr_cand[gi] = req_valid[gi] & req_we[gi];
      assign w_hazard[gi]  = w_wr_found && (req_addr[gi*AW +: AW] == w_wr_addr);
      assign w_rd_cand[gi] = req_valid[gi] & ~req_we[gi] & ~w_hazard[gi];
      assign req_ready[gi] = (w_wr_gnt && (w_wr_idx == PW'(gi))) ||
                             (w_rd_gnt && (w_rd_idx == PW'(gi)));
    end
  endgenerate

  assign ena   = ~rst;
  assign enb   = ~rst;
  assign wea   = w_wr_gnt;
  assign addra = w_wr_gnt ? w_wr_addr : '0;
  assign dia   = w_wr_gnt ? w_wr_data : '0;
  assign addrb = w_rd_gnt ? w_rd_addr : '0;

  // A response registered just before reset is squashed while reset is high.
  assign rsp_valid = rst ? '0 : r_rsp_valid;
  assign rsp_data  = dob;

  // Round-robin pointers advance past each winner; response tag follows the read grant.
  always_ff @(posedge clka) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rsp_valid <= '0;
    end else begin
      if (w_wr_found) begin
        r_wr_ptr <= (w_wr_idx == PW'(NREQ - 1)) ? '0 : w_wr_idx + 1'b1;
      end
      if (w_rd_found) begin
        r_rd_ptr    <= (w_rd_idx == PW'(NREQ - 1)) ? '0 : w_rd_idx + 1'b1;
        r_rsp_valid <= NREQ'(1) << w_rd_idx;
      end else begin
        r_rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: RAM model on ports A/B, a behavioural
// reference (round-robin search + golden memory) checked every cycle on the
// falling edge, directed scenarios with literal expectations, then random traffic.
module tb_ram_port_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 10;
  localparam int DW   = 16;

  logic              clka = 1'b0;
  logic              rst  = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              ena, enb, wea;
  logic [AW-1:0]     addra, addrb;
  logic [DW-1:0]     dia;
  logic [DW-1:0]     dob;

  int errors = 0;
  int checks = 0;

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clka(clka), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ena(ena), .enb(enb), .wea(wea), .addra(addra), .addrb(addrb),
    .dia(dia), .dob(dob)
  );

  always #5 clka = ~clka;

  // RAM: write port A, registered read port B.
  logic [DW-1:0] ram [1024];
  always @(posedge clka) begin
    if (ena && wea) ram[addra] <= dia;
    if (enb) dob <= ram[addrb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return req_wdata[i*DW +: DW];
  endfunction

  // Reference model state
  int              m_wr_ptr = 0;
  int              m_rd_ptr = 0;
  logic [DW-1:0]   m_mem [1024];
  logic [NREQ-1:0] m_rsp_v = '0;
  logic [DW-1:0]   m_rsp_d = '0;
  int              m_gw, m_gr, m_i;
  logic [NREQ-1:0] m_ready;

  // Per-cycle comparison against the model, then advance the model with this cycle's inputs.
  always @(negedge clka) begin
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wea",   32'(wea), 32'd0);
      chk("rst_ena",   32'(ena), 32'd0);
      chk("rst_enb",   32'(enb), 32'd0);
      chk("rst_addra", 32'(addra), 32'd0);
      chk("rst_addrb", 32'(addrb), 32'd0);
      chk("rst_dia",   32'(dia), 32'd0);
      chk("rst_rspv",  32'(rsp_valid), 32'd0);
      m_wr_ptr = 0;
      m_rd_ptr = 0;
      m_rsp_v  = '0;
    end else begin
      m_gw = -1;
      for (int k = 0; k < NREQ; k++) begin
        m_i = (m_wr_ptr + k) % NREQ;
        if (m_gw < 0 && req_valid[m_i] && req_we[m_i]) m_gw = m_i;
      end
      m_gr = -1;
      for (int k = 0; k < NREQ; k++) begin
        m_i = (m_rd_ptr + k) % NREQ;
        if (m_gr < 0 && req_valid[m_i] && !req_we[m_i] &&
            !(m_gw >= 0 && addr_of(m_i) == addr_of(m_gw))) m_gr = m_i;
      end
      m_ready = '0;
      if (m_gw >= 0) m_ready[m_gw] = 1'b1;
      if (m_gr >= 0) m_ready[m_gr] = 1'b1;
      chk("ready", 32'(req_ready), 32'(m_ready));
      chk("ena",   32'(ena), 32'd1);
      chk("enb",   32'(enb), 32'd1);
      chk("wea",   32'(wea), (m_gw >= 0) ? 32'd1 : 32'd0);
      chk("addra", 32'(addra), (m_gw >= 0) ? 32'(addr_of(m_gw)) : 32'd0);
      chk("dia",   32'(dia),   (m_gw >= 0) ? 32'(data_of(m_gw)) : 32'd0);
      chk("addrb", 32'(addrb), (m_gr >= 0) ? 32'(addr_of(m_gr)) : 32'd0);
      chk("rspv",  32'(rsp_valid), 32'(m_rsp_v));
      if (m_rsp_v != '0) chk("rspd", 32'(rsp_data), 32'(m_rsp_d));
      // Read sees memory before this cycle's write (never the same address).
      if (m_gr >= 0) begin
        m_rsp_v  = NREQ'(1) << m_gr;
        m_rsp_d  = m_mem[addr_of(m_gr)];
        m_rd_ptr = (m_gr + 1) % NREQ;
      end else begin
        m_rsp_v = '0;
      end
      if (m_gw >= 0) begin
        m_mem[addr_of(m_gw)] = data_of(m_gw);
        m_wr_ptr = (m_gw + 1) % NREQ;
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic reset_pulse();
    clear_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] acc;
  logic [NREQ-1:0] exp_oh;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]   <= DW'(i * 37) ^ 16'h5A5A;
      m_mem[i] = DW'(i * 37) ^ 16'h5A5A;
    end
    ram[32'h020]   <= 16'hBEEF;
    m_mem[32'h020] = 16'hBEEF;

    // Reset with all requesters valid
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(32'h30 + i), '0);
    rst = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      #3;
      chk("t1_rst_ready", 32'(req_ready), 32'd0);
      chk("t1_rst_wea", 32'(wea), 32'd0);
      chk("t1_rst_en", {30'd0, ena, enb}, 32'd0);
      tick();
    end
    rst = 1'b0;
    #3;
    chk("t1_rspv_after_rst", 32'(rsp_valid), 32'd0);
    chk("t1_first_read_gnt", 32'(req_ready), 32'b001);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    #3 chk("t1_second_gnt", 32'(req_ready), 32'b010);
    tick();
    set_req(1, 1'b0, 1'b0, '0, '0);
    #3 chk("t1_third_gnt", 32'(req_ready), 32'b100);
    tick();
    clear_all();
    tick();

    // Parallel read and write
    reset_pulse();
    set_req(0, 1'b1, 1'b1, 10'h010, 16'h1234);
    set_req(1, 1'b1, 1'b0, 10'h020, '0);
    #3;
    chk("t2_ready", 32'(req_ready), 32'b011);
    chk("t2_addra", 32'(addra), 32'h010);
    chk("t2_dia", 32'(dia), 32'h1234);
    chk("t2_addrb", 32'(addrb), 32'h020);
    tick();
    clear_all();
    #3;
    chk("t2_rspv", 32'(rsp_valid), 32'b010);
    chk("t2_rspd", 32'(rsp_data), 32'hBEEF);
    tick();

    // Same-address hazard
    reset_pulse();
    set_req(0, 1'b1, 1'b1, 10'h005, 16'hAAAA);
    set_req(2, 1'b1, 1'b0, 10'h005, '0);
    #3 chk("t3_c0_ready", 32'(req_ready), 32'b001);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    #3 chk("t3_c1_ready", 32'(req_ready), 32'b100);
    tick();
    clear_all();
    #3;
    chk("t3_rspv", 32'(rsp_valid), 32'b100);
    chk("t3_rspd", 32'(rsp_data), 32'hAAAA);
    tick();

    // Read round-robin, all continuously valid
    reset_pulse();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(32'h100 + i), '0);
    for (int k = 0; k < 6; k++) begin
      #3;
      exp_oh = NREQ'(1) << (k % 3);
      chk("t4_rr_ready", 32'(req_ready), 32'(exp_oh));
      if (k > 0) begin
        exp_oh = NREQ'(1) << ((k - 1) % 3);
        chk("t4_rr_rspv", 32'(rsp_valid), 32'(exp_oh));
      end
      tick();
    end
    clear_all();
    tick();

    // Write fairness with pointer wrap, req0 idle
    reset_pulse();
    set_req(1, 1'b1, 1'b1, 10'h200, 16'h1111);
    set_req(2, 1'b1, 1'b1, 10'h201, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("t5_wr_ready", 32'(req_ready), (k % 2 == 0) ? 32'b010 : 32'b100);
      tick();
    end
    clear_all();
    tick();

    // Reset right after a read grant
    reset_pulse();
    set_req(1, 1'b1, 1'b1, 10'h040, 16'h7777);
    #3 chk("t6_wr_gnt", 32'(req_ready), 32'b010);
    tick();
    set_req(1, 1'b1, 1'b0, 10'h040, '0);
    #3 chk("t6_rd_gnt", 32'(req_ready), 32'b010);
    tick();
    clear_all();
    rst = 1'b1;
    #3 chk("t6_no_rsp_in_rst", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(32'h50 + i), '0);
    #3;
    chk("t6_no_rsp_after", 32'(rsp_valid), 32'd0);
    chk("t6_rd_ptr0", 32'(req_ready), 32'b001);
    tick();
    clear_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, AW'(32'h60 + i), DW'(i));
    #3 chk("t6_wr_ptr0", 32'(req_ready), 32'b001);
    tick();
    clear_all();
    tick();

    // Random traffic; requests held until accepted, small address space for hazards
    reset_pulse();
    acc = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          if ($urandom_range(3) != 0)
            set_req(i, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
          else
            set_req(i, 1'b0, 1'b0, '0, '0);
        end
      end
      rst = ($urandom_range(199) == 0);
      #3;
      acc = req_valid & req_ready;
      @(posedge clka);
      #1;
    end
    rst = 1'b0;
    clear_all();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single-clock simple dual-port RAM (1024x16, write port A, read port B, 1-cycle registered read) between several on-chip requesters: instruction fetch, data load/store and the process/DMA loader. Every cycle it grants at most one write to port A and one read to port B. Read and write use independent round-robin pointers. It blocks same-cycle read-after-write hazards and returns read data to the granted requester one cycle after the grant.

## Interface
- NREQ, 3, number of requesters (index 0..NREQ-1)
- AW, 10, RAM address width
- DW, 16, RAM data width

- clka  in  1  clock; also drives both RAM clocks (clka, clkb)
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  NREQ  request pending per requester; held until accepted
- req_we  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- req_ready  out  NREQ  grant; the request is accepted in a cycle where req_valid[i] && req_ready[i]
- rsp_valid  out  NREQ  one-hot read-data-valid, one cycle after a read grant
- rsp_data  out  DW  read data, shared by all requesters, qualified by rsp_valid
- ena, enb  out  1  RAM port enables
- wea  out  1  RAM write enable
- addra, addrb  out  AW  RAM write and read addresses
- dia  out  DW  RAM write data
- dob  in  DW  RAM read data

## Operation
- Requester classes each cycle:
  - W = {i : req_valid[i] && req_we[i]}
  - R = {i : req_valid[i] && !req_we[i]}
- Write arbitration: round-robin over W, starting at wr_ptr.
  - The winner gw gets req_ready[gw]=1, wea=1, addra=req_addr[gw], dia=req_wdata[gw].
  - wr_ptr <= (gw+1) mod NREQ.
  - If W is empty: wea=0, wr_ptr unchanged.
- Read arbitration: round-robin over R' starting at rd_ptr.
  - R' = R minus any reader whose req_addr equals addra of the write granted this cycle (hazard mask).
  - The winner gr gets req_ready[gr]=1, addrb=req_addr[gr].
  - rd_ptr <= (gr+1) mod NREQ.
  - If R' is empty: no read grant, rd_ptr unchanged.
  - A masked reader is retried the next cycle and then sees the new data.
- Grants, wea, addra, addrb and dia are combinational from the request inputs and the pointers. They are not registered.
- A requester holds at most one request. It never receives both a read and a write grant.
- Response path:
  - rsp_valid <= onehot(gr) when a read was granted, else 0.
  - rsp_data = dob, passed through.
- ena=enb=1 whenever rst=0.
- Fairness: a continuously valid requester is granted within NREQ grants of its class.
- Requesters must keep req_addr, req_wdata and req_we stable while req_valid=1 and req_ready=0. Dropping req_valid before the grant is illegal.
- Unused addrb and addra are driven to 0 when not granted. dia is driven to 0 when no write is granted.

## Timing
- While rst=1 (combinational override): req_ready=0, wea=0, ena=0, enb=0, addra=addrb=0, dia=0.
- On a rst=1 edge:
  - wr_ptr, rd_ptr <= 0.
  - rsp_valid <= 0, so it reads 0 the cycle after reset is released.
- Reset mid-operation: a read granted in the cycle before rst produces no rsp_valid. A write whose grant was visible at the rst edge is suppressed, because wea is forced 0.
- Write latency: the RAM is updated at the clka edge ending the grant cycle.
- Read latency: grant in cycle N; rsp_valid and rsp_data valid in cycle N+1.
- Throughput: one read and one write per cycle, back-to-back, with no bubbles.
- Simultaneous read and write to the same address: the write is granted and the read is deferred at least one cycle. Read data therefore always reflects the completed write.
- Pointer wrap: from NREQ-1 to 0.

## Test plan
- Reset: hold rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, wea=0, ena=enb=0. After release, rsp_valid=0 and the first grants go to requester 0 (read and write).
- Parallel read and write: req0 writes 0x1234 to 0x010 and req1 reads 0x020 (preloaded 0xBEEF) in the same cycle -> both granted. The next cycle gives rsp_valid=3'b010 and rsp_data=0xBEEF.
- Hazard: req0 writes 0xAAAA to 0x005 while req2 reads 0x005 -> cycle 0 grants the write only. Cycle 1 grants the read. Cycle 2 gives rsp_valid=3'b100 and rsp_data=0xAAAA.
- Round-robin: all three requesters read continuously from 0x100/0x101/0x102 -> grant order 0,1,2,0,1,2 and rsp_valid one-hot in the same order, one cycle later.
- Write fairness with wrap: req1 and req2 write continuously -> grants alternate 1,2,1,2. wr_ptr wraps through 0 without granting idle req0.
- Reset mid-stream: assert rst in the cycle after a read grant to req1 -> no rsp_valid pulse, and both pointers return to 0.
